// File: rtl/seg7_pkg.sv
// Shared seven-segment constants, digit table, BCD sizing helper and sequencer
// state type for the BCD display path. Segment patterns are active-low {g,f,e,d,c,b,a}.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Entry n is the pattern for decimal digit n.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    // Decimal digits needed to hold any data_w-bit unsigned magnitude.
    function automatic int nbcd_digits(input int data_w);
        return (data_w * 3) / 10 + 1;
    endfunction

endpackage

// File: rtl/seg7_encode.sv
// One seven-segment digit: maps a BCD nibble to segments, with dash taking
// priority over blank, then flips polarity for active-high displays.
module seg7_encode
    import seg7_pkg::*;
#(
    parameter int ACTIVE_LOW = 1
) (
    input  logic [3:0] digit,
    input  logic       blank,
    input  logic       dash,
    output logic [6:0] seg
);

    logic [6:0] raw_s;

    // Select active-low pattern; codes above 9 never occur but render blank.
    always_comb begin
        raw_s = SEG_BLANK;
        if (dash) begin
            raw_s = SEG_DASH;
        end else if (blank) begin
            raw_s = SEG_BLANK;
        end else if (digit <= 4'd9) begin
            raw_s = SEG_TABLE[digit];
        end else begin
            raw_s = SEG_BLANK;
        end
    end

    assign seg = (ACTIVE_LOW != 0) ? raw_s : ~raw_s;

endmodule

// File: rtl/bcd_display_seq.sv
// Sequential binary-to-seven-segment display driver: accepts a signed/unsigned
// value, converts its magnitude with a shift-add-3 engine, and holds registered digits.
module bcd_display_seq
    import seg7_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int DIGITS     = 8,
    parameter int BLANK_LZ   = 1,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_signed,
    output logic [7*DIGITS-1:0]   seg_out,
    output logic [6:0]            sign_seg,
    output logic                  ovf,
    output logic                  busy,
    output logic                  done
);

    localparam int NBCD = nbcd_digits(DATA_W);
    localparam int BW   = 4 * NBCD;
    localparam int NPAD = (NBCD > DIGITS) ? NBCD : DIGITS;
    localparam int PW   = 4 * NPAD;
    localparam int CW   = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST_CNT  = CW'(DATA_W - 1);
    localparam logic [6:0]    BLANK_OUT = (ACTIVE_LOW != 0) ? SEG_BLANK : ~SEG_BLANK;
    localparam logic [6:0]    DASH_OUT  = (ACTIVE_LOW != 0) ? SEG_DASH  : ~SEG_DASH;

    state_t                   state_r;
    state_t                   state_nxt_s;
    logic                     in_ready_s;
    logic                     busy_s;
    logic                     accept_s;
    logic                     load_s;
    logic                     last_s;
    logic                     neg_in_s;
    logic [DATA_W-1:0]        mag_in_s;

    logic                     neg_r;
    logic [DATA_W-1:0]        mag_r;
    logic [BW-1:0]            bcd_r;
    logic [BW-1:0]            bcd_adj_s;
    logic [CW-1:0]            cnt_r;

    logic [PW-1:0]            bcd_pad_s;
    logic                     ovf_s;
    int                       msd_s;
    logic [DIGITS-1:0][3:0]   disp_digit_s;
    logic [DIGITS-1:0]        disp_blank_s;
    logic [DIGITS-1:0][6:0]   enc_seg_s;

    logic [7*DIGITS-1:0]      seg_r;
    logic [6:0]               sign_r;
    logic                     ovf_r;
    logic                     done_r;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_nxt_s = CONV;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CONV: begin
                if (last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = CONV;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State-decoded control outputs.
    always_comb begin
        in_ready_s = 1'b0;
        busy_s     = 1'b0;
        accept_s   = 1'b0;
        load_s     = 1'b0;
        case (state_r)
            IDLE: begin
                in_ready_s = 1'b1;
                accept_s   = in_valid;
            end
            CONV: begin
                busy_s = 1'b1;
            end
            DONE: begin
                busy_s = 1'b1;
                load_s = 1'b1;
            end
            default: begin
                in_ready_s = 1'b0;
            end
        endcase
    end

    assign last_s   = (cnt_r == LAST_CNT);
    assign neg_in_s = (in_signed != 1'b0) & in_data[DATA_W-1];
    // Plain negate handles the most-negative value: its magnitude fits unsigned.
    assign mag_in_s = neg_in_s ? (~in_data + DATA_W'(1)) : in_data;

    // Add-3 correction on every nibble that would reach 10 or more after the shift.
    always_comb begin
        bcd_adj_s = bcd_r;
        for (int k = 0; k < NBCD; k++) begin
            if (bcd_r[4*k +: 4] >= 4'd5) begin
                bcd_adj_s[4*k +: 4] = bcd_r[4*k +: 4] + 4'd3;
            end else begin
                bcd_adj_s[4*k +: 4] = bcd_r[4*k +: 4];
            end
        end
    end

    // Conversion datapath: capture on accept, shift one bit per CONV cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_r <= 1'b0;
            mag_r <= '0;
            bcd_r <= '0;
            cnt_r <= '0;
        end else if (accept_s) begin
            neg_r <= neg_in_s;
            mag_r <= mag_in_s;
            bcd_r <= '0;
            cnt_r <= '0;
        end else if (state_r == CONV) begin
            bcd_r <= {bcd_adj_s[BW-2:0], mag_r[DATA_W-1]};
            mag_r <= {mag_r[DATA_W-2:0], 1'b0};
            cnt_r <= cnt_r + CW'(1);
        end else begin
            neg_r <= neg_r;
            mag_r <= mag_r;
            bcd_r <= bcd_r;
            cnt_r <= cnt_r;
        end
    end

    assign bcd_pad_s = PW'(bcd_r);

    // Overflow, most significant nonzero digit, and per-digit blanking.
    always_comb begin
        ovf_s        = 1'b0;
        msd_s        = 0;
        disp_digit_s = '0;
        disp_blank_s = '0;
        for (int k = 0; k < NPAD; k++) begin
            if (bcd_pad_s[4*k +: 4] != 4'd0) begin
                msd_s = k;
                if (k >= DIGITS) begin
                    ovf_s = 1'b1;
                end else begin
                    ovf_s = ovf_s;
                end
            end else begin
                msd_s = msd_s;
            end
        end
        for (int k = 0; k < DIGITS; k++) begin
            disp_digit_s[k] = bcd_pad_s[4*k +: 4];
            disp_blank_s[k] = (BLANK_LZ != 0) && (k > msd_s);
        end
    end

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_enc
            seg7_encode #(
                .ACTIVE_LOW (ACTIVE_LOW)
            ) u_enc (
                .digit (disp_digit_s[g]),
                .blank (disp_blank_s[g]),
                .dash  (ovf_s),
                .seg   (enc_seg_s[g])
            );
        end
    endgenerate

    // Display registers hold the last result until the next conversion finishes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_r  <= {DIGITS{BLANK_OUT}};
            sign_r <= BLANK_OUT;
            ovf_r  <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= load_s;
            if (load_s) begin
                seg_r  <= enc_seg_s;
                sign_r <= neg_r ? DASH_OUT : BLANK_OUT;
                ovf_r  <= ovf_s;
            end else begin
                seg_r  <= seg_r;
                sign_r <= sign_r;
                ovf_r  <= ovf_r;
            end
        end
    end

    assign in_ready = in_ready_s;
    assign busy     = busy_s;
    assign seg_out  = seg_r;
    assign sign_seg = sign_r;
    assign ovf      = ovf_r;
    assign done     = done_r;

endmodule

// File: tb/tb_bcd_display_seq.sv
// Scoreboard bench for bcd_display_seq: two instances (blanking on/off) share
// stimulus; a decimal reference model predicts each display.
module tb_bcd_display_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_signed = 1'b0;
    logic [31:0] in_data = 32'd0;

    logic [55:0] seg_a, seg_b;
    logic [6:0]  sign_a, sign_b;
    logic        ovf_a, ovf_b, busy_a, busy_b, done_a, done_b, rdy_a, rdy_b;

    bcd_display_seq #(.DATA_W(32), .DIGITS(8), .BLANK_LZ(1), .ACTIVE_LOW(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_a),
        .in_data(in_data), .in_signed(in_signed), .seg_out(seg_a),
        .sign_seg(sign_a), .ovf(ovf_a), .busy(busy_a), .done(done_a));

    bcd_display_seq #(.DATA_W(32), .DIGITS(8), .BLANK_LZ(0), .ACTIVE_LOW(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_b),
        .in_data(in_data), .in_signed(in_signed), .seg_out(seg_b),
        .sign_seg(sign_b), .ovf(ovf_b), .busy(busy_b), .done(done_b));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [55:0] seg;
        logic [6:0]  sign;
        logic        ovf;
        int          e0;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   passed = 0;
    int   total = 0;
    bit   stim_done = 1'b0;

    function automatic logic [6:0] enc(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Decimal reference: magnitude by subtraction from 2^32, digits by div/mod.
    function automatic exp_t model(input logic [31:0] d, input bit s, input bit blz, input int e0);
        exp_t r;
        longint unsigned mag;
        longint unsigned pw;
        bit neg;
        neg    = s && d[31];
        mag    = neg ? (64'd4294967296 - {32'd0, d}) : {32'd0, d};
        r.ovf  = (mag >= 64'd100000000);
        r.sign = neg ? 7'b0111111 : 7'b1111111;
        r.seg  = '0;
        pw     = 64'd1;
        for (int k = 0; k < 8; k++) begin
            if (r.ovf)
                r.seg[7*k +: 7] = 7'b0111111;
            else if (blz && k > 0 && mag < pw)
                r.seg[7*k +: 7] = 7'b1111111;
            else
                r.seg[7*k +: 7] = enc(int'((mag / pw) % 64'd10));
            pw = pw * 64'd10;
        end
        r.e0 = e0;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic idle_checks(input string tag);
        check({tag, "_seg_a"}, {8'd0, seg_a}, {8'd0, {8{7'b1111111}}});
        check({tag, "_seg_b"}, {8'd0, seg_b}, {8'd0, {8{7'b1111111}}});
        check({tag, "_sign_a"}, {57'd0, sign_a}, 64'h7f);
        check({tag, "_sign_b"}, {57'd0, sign_b}, 64'h7f);
        check({tag, "_ovf"}, {62'd0, ovf_a, ovf_b}, 64'd0);
        check({tag, "_done"}, {62'd0, done_a, done_b}, 64'd0);
        check({tag, "_busy"}, {62'd0, busy_a, busy_b}, 64'd0);
        check({tag, "_ready"}, {62'd0, rdy_a, rdy_b}, 64'd3);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [31:0] d, input bit s, input bit hold, output int e0);
        int n;
        in_data   = d;
        in_signed = s;
        in_valid  = 1'b1;
        n = 0;
        while (!(rdy_a && rdy_b) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            check("accept_timeout", {62'd0, rdy_a, rdy_b}, 64'd3);
            in_valid = 1'b0;
            e0 = cyc;
        end else begin
            e0 = cyc + 1;
            qa.push_back(model(d, s, 1'b1, e0));
            qb.push_back(model(d, s, 1'b0, e0));
            @(negedge clk);
            if (!hold) in_valid = 1'b0;
        end
    endtask

    task automatic compare_done(input string tag, input logic [55:0] seg, input logic [6:0] sign,
                                input logic ov, input logic rdy, input exp_t e);
        check({tag, "_seg"}, {8'd0, seg}, {8'd0, e.seg});
        check({tag, "_sign"}, {57'd0, sign}, {57'd0, e.sign});
        check({tag, "_ovf"}, {63'd0, ov}, {63'd0, e.ovf});
        check({tag, "_latency"}, 64'(cyc - e.e0), 64'd33);
        check({tag, "_ready"}, {63'd0, rdy}, 64'd1);
    endtask

    initial begin
        fork
            begin : stimulus
                int e1, e2, n;
                logic [31:0] d;
                bit s;
                repeat (3) @(negedge clk);
                idle_checks("reset");
                rst_n = 1'b1;
                @(negedge clk);

                send(32'hFFFFFFFF, 1'b1, 1'b0, e1);
                send(32'h80000000, 1'b1, 1'b0, e1);
                send(32'h80000000, 1'b0, 1'b0, e1);
                send(32'd0, 1'b0, 1'b0, e1);
                send(32'd42, 1'b0, 1'b0, e1);
                send(32'd99999999, 1'b0, 1'b0, e1);
                send(32'd100000000, 1'b0, 1'b0, e1);
                send(32'hFA0A1F01, 1'b1, 1'b0, e1);

                send(32'd12345678, 1'b0, 1'b1, e1);
                send(32'd87654321, 1'b0, 1'b0, e2);
                check("b2b_gap", 64'(e2 - e1), 64'd34);

                for (int i = 0; i < 16; i++) begin
                    s = 1'($urandom_range(0, 1));
                    case ($urandom_range(0, 3))
                        0: d = $urandom();
                        1: d = $urandom_range(0, 99999);
                        2: begin d = $urandom_range(1, 99999); d = ~d + 32'd1; s = 1'b1; end
                        default: d = $urandom_range(99990000, 100010000);
                    endcase
                    send(d, s, 1'b0, e1);
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                end

                send(32'd123456, 1'b0, 1'b0, e1);
                repeat (9) @(negedge clk);
                rst_n = 1'b0;
                qa.delete();
                qb.delete();
                #1;
                idle_checks("midreset");
                @(negedge clk);
                rst_n = 1'b1;
                repeat (40) @(negedge clk);
                send(32'd7, 1'b0, 1'b0, e1);

                n = 0;
                while ((qa.size() != 0 || qb.size() != 0) && n < 300) begin
                    @(negedge clk);
                    n++;
                end
                check("drain_pending", 64'(qa.size() + qb.size()), 64'd0);
                stim_done = 1'b1;
            end
            begin : monitor
                exp_t e;
                while (!stim_done) begin
                    @(negedge clk);
                    if (done_a) begin
                        if (qa.size() == 0) check("done_a_unexpected", {63'd0, done_a}, 64'd0);
                        else begin
                            e = qa.pop_front();
                            compare_done("a", seg_a, sign_a, ovf_a, rdy_a, e);
                        end
                    end
                    if (done_b) begin
                        if (qb.size() == 0) check("done_b_unexpected", {63'd0, done_b}, 64'd0);
                        else begin
                            e = qb.pop_front();
                            compare_done("b", seg_b, sign_b, ovf_b, rdy_b, e);
                        end
                    end
                end
            end
        join
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
